ahb_tty_uart: RTL

AHB_TTY_UART -- requirements
Module: ahb_tty_uart

---
 rtl/ahb_tty_uart.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_tty_uart.sv
`default_nettype none
// ============================================================================
// Module   : ahb_tty_uart
// Brief    : AHB-Lite transmit-only TTY UART (TX FIFO, 8N1 serializer).
//            Optional TTY_STOP_EN: a DATA write of 8'hFF raises sticky STOP.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_tty_uart #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [11:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        TXD,
    output logic        TX_BUSY,
    output logic        STOP
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stopb = 2'd3;

    logic               r_dp_valid;
    logic               r_dp_write;
    logic [1:0]         r_dp_addr;
    logic [15:0]        r_baud;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [1:0]         r_state;
    logic [15:0]        r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    logic        w_addr_phase;
    logic        w_data_wr;
    logic        w_baud_wr;
    logic        w_is_stop;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_stall;
    logic        w_full;
    logic        w_empty;
    logic        w_bit_end;
    logic [15:0] w_bit_reload;
    logic [1:0]  w_next_state;
    logic        w_txd;
    logic [31:0] w_count_ext;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_addr_phase = HSEL & HTRANS[1] & HREADY;
    assign w_data_wr    = r_dp_valid & r_dp_write & (r_dp_addr == 2'd0);
    assign w_baud_wr    = r_dp_valid & r_dp_write & (r_dp_addr == 2'd2);
    assign w_full       = (r_count == c_full_count);
    assign w_empty      = (r_count == '0);
    assign w_push_req   = w_data_wr & ~w_is_stop;
    // A full FIFO still accepts the write in the cycle the serializer pops.
    assign w_push       = w_push_req & (~w_full | w_pop);
    assign w_stall      = w_push_req & w_full & ~w_pop;
    assign w_bit_end    = (r_bit_cnt == 16'd0);
    assign w_bit_reload = (r_baud == 16'd0) ? 16'd0 : (r_baud - 16'd1);
    assign w_count_ext  = 32'(r_count);
    assign w_status     = {19'd0, w_count_ext[4:0], 5'd0, w_empty, w_full, TX_BUSY};
    assign w_unused     = ^{HSIZE, HADDR[11:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign HREADYOUT = ~w_stall;
    assign HRESP     = 1'b0;
    assign TXD       = w_txd;
    assign TX_BUSY   = (r_state != c_st_idle) | ~w_empty;

`ifdef TTY_STOP_EN
    logic r_stop;
    assign w_is_stop = (HWDATA[7:0] == 8'hFF);
    assign STOP      = r_stop;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_stop <= 1'b0;
        end else if (w_data_wr && w_is_stop) begin
            r_stop <= 1'b1;
        end
    end
`else
    assign w_is_stop = 1'b0;
    assign STOP      = 1'b0;
`endif

    always_comb begin
        HRDATA = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                2'd1:    HRDATA = w_status;
                2'd2:    HRDATA = {16'd0, r_baud};
                default: HRDATA = 32'd0;
            endcase
        end
    end

    // A stalled data phase is held so HWDATA is consumed when space frees up.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'd0;
            r_baud     <= BAUD_DIV_RST;
        end else begin
            if (!w_stall) begin
                r_dp_valid <= w_addr_phase;
                r_dp_write <= HWRITE;
                r_dp_addr  <= HADDR[3:2];
            end
            if (w_baud_wr) begin
                r_baud <= HWDATA[15:0];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push && !HRESET) begin
            r_mem[r_wr_ptr] <= HWDATA[7:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_txd        = 1'b1;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_next_state = c_st_start;
                    w_pop        = 1'b1;
                end
            end
            c_st_start: begin
                w_txd = 1'b0;
                if (w_bit_end) w_next_state = c_st_data;
            end
            c_st_data: begin
                w_txd = r_shift[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = c_st_stopb;
            end
            c_st_stopb: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_next_state = c_st_start;
                        w_pop        = 1'b1;
                    end else begin
                        w_next_state = c_st_idle;
                    end
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // The bit counter reloads from BAUDDIV only at bit boundaries.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_bit_cnt <= w_bit_reload;
            end else if (r_state != c_st_idle) begin
                if (w_bit_end) begin
                    r_bit_cnt <= w_bit_reload;
                    if (r_state == c_st_start) begin
                        r_bit_idx <= 3'd0;
                    end
                    if (r_state == c_st_data) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt - 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
